// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift register controller: command opcodes, FSM states
// and the datapath mode select.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        MODE_HOLD,
        MODE_LOAD,
        MODE_SHL,
        MODE_SHR,
        MODE_ROTL
    } mode_e;

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, parallel load, shift left/right
// with serial fill, and rotate left.
module univ_shift_reg
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  mode_e            mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            unique case (mode)
                MODE_LOAD: q <= load_data;
                MODE_SHL:  q <= {q[WIDTH-2:0], ser_in};
                MODE_SHR:  q <= {ser_in, q[WIDTH-1:1]};
                MODE_ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Command-driven sequencer for univ_shift_reg: LOAD, counted SHL/SHR/ROTL.
// Define SHIFT_CTRL_ABORT_EN to add an abort input that cancels a running shift.
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SHIFT_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state;
    op_e              op_r;
    logic [CNT_W-1:0] cnt;
    mode_e            mode;
    op_e              cmd_op_e;
    logic             accept;
    logic             abort_hit;

    assign cmd_op_e = op_e'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;

`ifdef SHIFT_CTRL_ABORT_EN
    assign abort_hit = abort && (state == ST_SHIFT);
`else
    assign abort_hit = 1'b0;
`endif

    // LOAD writes the register on the accept edge itself; shifts only step in SHIFT.
    always_comb begin
        mode = MODE_HOLD;
        if (accept && cmd_op_e == OP_LOAD) begin
            mode = MODE_LOAD;
        end else if (state == ST_SHIFT && !abort_hit) begin
            unique case (op_r)
                OP_SHL:  mode = MODE_SHL;
                OP_SHR:  mode = MODE_SHR;
                OP_ROTL: mode = MODE_ROTL;
                default: mode = MODE_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_r      <= OP_SHL;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r      <= cmd_op_e;
                        cnt       <= cmd_count;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op_e == OP_LOAD || cmd_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (abort_hit) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign ser_out = (state != ST_IDLE && op_r == OP_SHR) ? q[0] : q[WIDTH-1];

    univ_shift_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .ser_in    (ser_in),
        .load_data (cmd_data),
        .q         (q)
    );

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_shift_reg_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             ser_in = 1'b0;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;
`ifdef SHIFT_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_reg_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SHIFT_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Reference model: register value as an integer, remaining shift steps, and
    // the number of cycles the command still occupies before ready returns.
    int m_q, m_op, m_steps, m_busy_left;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q = 0;
        m_op = 1;
        m_steps = 0;
        m_busy_left = 0;
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            model_reset();
        end else if (m_busy_left > 0) begin
`ifdef SHIFT_CTRL_ABORT_EN
            if (abort && m_steps > 0) begin
                m_steps = 0;
                m_busy_left = 0;
                return;
            end
`endif
            if (m_steps > 0) begin
                case (m_op)
                    1: m_q = ((m_q * 2) + int'(ser_in)) % 16;
                    2: m_q = (m_q / 2) + 8 * int'(ser_in);
                    3: m_q = ((m_q * 2) % 16) + (m_q / 8);
                    default: ;
                endcase
                m_steps--;
            end
            m_busy_left--;
        end else if (cmd_valid) begin
            m_op = int'(cmd_op);
            if (m_op == 0) begin
                m_q = int'(cmd_data);
                m_steps = 0;
            end else begin
                m_steps = int'(cmd_count);
            end
            m_busy_left = m_steps + 1;
        end
    endfunction

    function automatic void compare_all();
        int exp_ser;
        exp_ser = (m_busy_left != 0 && m_op == 2) ? (m_q % 2) : (m_q / 8);
        chk("q", int'(q), m_q);
        chk("cmd_ready", int'(cmd_ready), int'(m_busy_left == 0));
        chk("busy", int'(busy), int'(m_busy_left != 0));
        chk("done", int'(done), int'(m_busy_left == 1));
        chk("ser_out", int'(ser_out), exp_ser);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        done_seen += int'(done);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                           input logic [2:0] count, input logic ser);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        ser_in    = ser;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            tick();
        end
        chk("ready_timeout", int'(cmd_ready), 1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [2:0] count;
        logic       ser;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 4'b1010, 3'd0, 1'b0, 4'b1010};
        vecs[1] = '{2'b01, 4'b0000, 3'd2, 1'b1, 4'b1011};
        vecs[2] = '{2'b00, 4'b1100, 3'd5, 1'b0, 4'b1100};
        vecs[3] = '{2'b10, 4'b1111, 3'd3, 1'b0, 4'b0001};
        vecs[4] = '{2'b00, 4'b1001, 3'd0, 1'b0, 4'b1001};
        vecs[5] = '{2'b11, 4'b0000, 3'd4, 1'b1, 4'b1001};
        vecs[6] = '{2'b01, 4'b0110, 3'd0, 1'b1, 4'b1001};
        vecs[7] = '{2'b10, 4'b0000, 3'd2, 1'b1, 4'b1110};
        vecs[8] = '{2'b11, 4'b0000, 3'd7, 1'b0, 4'b0111};
        vecs[9] = '{2'b00, 4'b0000, 3'd0, 1'b0, 4'b0000};

        // Reset state
        model_reset();
        tick();
        tick();
        chk("rst_q", int'(q), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b1;
        tick();

        // Directed vector table
        foreach (vecs[k]) begin
            done_seen = 0;
            run_cmd(vecs[k].op, vecs[k].data, vecs[k].count, vecs[k].ser);
            chk($sformatf("vec%0d_q", k), int'(q), int'(vecs[k].exp_q));
            chk($sformatf("vec%0d_done_cnt", k), done_seen, 1);
        end

        // cmd_valid held through a busy command: LOAD waits for IDLE
        run_cmd(2'b00, 4'b1111, 3'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 3'd3;
        ser_in    = 1'b0;
        tick();
        cmd_op   = 2'b00;
        cmd_data = 4'b0110;
        for (int i = 0; i < 20; i++) begin
            if (q == 4'b0110) break;
            tick();
        end
        cmd_valid = 1'b0;
        chk("held_load_q", int'(q), 6);
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            tick();
        end

        // Asynchronous reset in the middle of SHL N=7
        run_cmd(2'b00, 4'b1111, 3'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 3'd7;
        ser_in    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_q", int'(q), 15);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_q", int'(q), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        compare_all();
        tick();
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("no_done_after_rst", done_seen, 0);

`ifdef SHIFT_CTRL_ABORT_EN
        // Abort after two SHL steps with ser_in=0
        run_cmd(2'b00, 4'b1111, 3'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 3'd7;
        ser_in    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        done_seen = 0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_q", int'(q), 12);
        chk("abort_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", done_seen, 0);
        chk("abort_q_hold", int'(q), 12);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = 4'($urandom_range(0, 15));
            cmd_count = 3'($urandom_range(0, 7));
            ser_in    = 1'($urandom_range(0, 1));
`ifdef SHIFT_CTRL_ABORT_EN
            abort     = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end
        cmd_valid = 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 12; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
